// File: rtl/vga_bus_pkg.sv
// Shared types and constants for the VGA register-bus initiator.
// Holds the phase-state encoding, VGA register addresses and a helper for phase-timer sizing.
package vga_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        HOLD     = 3'd3,
        RECOVER  = 3'd4,
        POLL_RD  = 3'd5,
        POLL_CHK = 3'd6
    } state_e;

    localparam logic [3:0] ADDR_STATUS     = 4'd0;
    localparam logic [3:0] ADDR_CTRL       = 4'd2;
    localparam logic [3:0] ADDR_DATA       = 4'd3;
    localparam int         STATUS_BUSY_BIT = 0;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vga_bus_timer.sv
// Loadable down-counter shared by all bus phases; o_done is high while the count is zero.
// Loading N-1 at phase entry makes the phase last exactly N cycles.
module vga_bus_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/vga_bus_master.sv
// Turns a valid/ready request stream into timed ncs/nwr/nrd cycles on the VGA core's register bus.
// Define VGA_BUS_MASTER_BUSY_POLL_EN to poll the status busy bit before every write to the data register.
module vga_bus_master
    import vga_bus_pkg::*;
#(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 5,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 8,
    parameter int POLL_LIMIT   = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       bus_ncs,
    output logic       bus_nwr,
    output logic       bus_nrd,
    output logic [3:0] bus_addr,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din,
    output logic       poll_timeout
);

    localparam int PHASE_MAX = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [PHASE_W-1:0] SETUP_LOAD    = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0] STROBE_LOAD   = PHASE_W'(STROBE_CYC - 1);
    localparam logic [PHASE_W-1:0] HOLD_LOAD     = PHASE_W'(HOLD_CYC - 1);
    localparam logic [PHASE_W-1:0] RECOVERY_LOAD = PHASE_W'(RECOVERY_CYC - 1);

    state_e       r_state, w_state_next;
    logic         r_write, w_write_next;
    logic         r_ncs, w_ncs_next;
    logic         r_nwr, w_nwr_next;
    logic         r_nrd, w_nrd_next;
    logic [3:0]   r_bus_addr, w_bus_addr_next;
    logic [7:0]   r_bus_dout, w_bus_dout_next;
    logic         r_rsp_valid, w_rsp_valid_next;
    logic [7:0]   r_rsp_rdata, w_rsp_rdata_next;
    logic         w_load;
    logic [PHASE_W-1:0] w_load_val;
    logic         w_done;
    logic         w_cyc_write;

`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
    localparam int POLL_CNT_W = $clog2(POLL_LIMIT + 1);

    logic [3:0]            r_addr, w_addr_next;
    logic [7:0]            r_wdata, w_wdata_next;
    logic                  r_poll, w_poll_next;
    logic                  r_busy, w_busy_next;
    logic [POLL_CNT_W-1:0] r_busy_cnt, w_busy_cnt_next;
    logic                  r_timeout, w_timeout_next;

    // A poll cycle is always a read, whatever the pending request is.
    assign w_cyc_write  = r_write && !r_poll;
    assign poll_timeout = r_timeout;
`else
    assign w_cyc_write  = r_write;
    assign poll_timeout = 1'b0;
`endif

    vga_bus_timer #(
        .W(PHASE_W)
    ) u_timer (
        .clk    (clk),
        .nrst   (nrst),
        .i_load (w_load),
        .i_value(w_load_val),
        .o_done (w_done)
    );

    always_comb begin
        w_state_next     = r_state;
        w_write_next     = r_write;
        w_ncs_next       = r_ncs;
        w_nwr_next       = r_nwr;
        w_nrd_next       = r_nrd;
        w_bus_addr_next  = r_bus_addr;
        w_bus_dout_next  = r_bus_dout;
        w_rsp_valid_next = 1'b0;
        w_rsp_rdata_next = r_rsp_rdata;
        w_load           = 1'b0;
        w_load_val       = '0;
`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_poll_next      = r_poll;
        w_busy_next      = r_busy;
        w_busy_cnt_next  = r_busy_cnt;
        w_timeout_next   = r_timeout;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_write_next = req_write;
`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
                    w_addr_next  = req_addr;
                    w_wdata_next = req_wdata;
                    if (req_write && req_addr == ADDR_DATA) begin
                        w_state_next    = POLL_RD;
                        w_busy_cnt_next = '0;
                    end else
`endif
                    begin
                        w_state_next    = SETUP;
                        w_load          = 1'b1;
                        w_load_val      = SETUP_LOAD;
                        w_bus_addr_next = req_addr;
                        if (req_write) w_bus_dout_next = req_wdata;
                    end
                end
            end
            SETUP: begin
                if (w_done) begin
                    w_state_next = STROBE;
                    w_load       = 1'b1;
                    w_load_val   = STROBE_LOAD;
                    w_ncs_next   = 1'b0;
                    if (w_cyc_write) w_nwr_next = 1'b0;
                    else             w_nrd_next = 1'b0;
                end
            end
            STROBE: begin
                // Read data is taken on the edge that releases the strobes.
                if (w_done) begin
                    w_state_next = HOLD;
                    w_load       = 1'b1;
                    w_load_val   = HOLD_LOAD;
                    w_ncs_next   = 1'b1;
                    w_nwr_next   = 1'b1;
                    w_nrd_next   = 1'b1;
                    if (!w_cyc_write) begin
`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
                        if (r_poll) begin
                            w_busy_next = bus_din[STATUS_BUSY_BIT];
                        end else
`endif
                        begin
                            w_rsp_rdata_next = bus_din;
                            w_rsp_valid_next = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_done) begin
                    w_state_next = RECOVER;
                    w_load       = 1'b1;
                    w_load_val   = RECOVERY_LOAD;
                end
            end
            RECOVER: begin
                if (w_done) begin
`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
                    w_state_next = r_poll ? POLL_CHK : IDLE;
`else
                    w_state_next = IDLE;
`endif
                end
            end
`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
            POLL_RD: begin
                w_state_next    = SETUP;
                w_load          = 1'b1;
                w_load_val      = SETUP_LOAD;
                w_bus_addr_next = ADDR_STATUS;
                w_poll_next     = 1'b1;
            end
            POLL_CHK: begin
                if (r_busy && (int'(r_busy_cnt) + 1 < POLL_LIMIT)) begin
                    w_busy_cnt_next = r_busy_cnt + 1'b1;
                    w_state_next    = POLL_RD;
                end else begin
                    if (r_busy) w_timeout_next = 1'b1;
                    w_poll_next     = 1'b0;
                    w_bus_addr_next = r_addr;
                    w_bus_dout_next = r_wdata;
                    w_state_next    = SETUP;
                    w_load          = 1'b1;
                    w_load_val      = SETUP_LOAD;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_ncs       <= 1'b1;
            r_nwr       <= 1'b1;
            r_nrd       <= 1'b1;
            r_bus_addr  <= '0;
            r_bus_dout  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
            r_addr      <= '0;
            r_wdata     <= '0;
            r_poll      <= 1'b0;
            r_busy      <= 1'b0;
            r_busy_cnt  <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_write     <= w_write_next;
            r_ncs       <= w_ncs_next;
            r_nwr       <= w_nwr_next;
            r_nrd       <= w_nrd_next;
            r_bus_addr  <= w_bus_addr_next;
            r_bus_dout  <= w_bus_dout_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
`ifdef VGA_BUS_MASTER_BUSY_POLL_EN
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_poll      <= w_poll_next;
            r_busy      <= w_busy_next;
            r_busy_cnt  <= w_busy_cnt_next;
            r_timeout   <= w_timeout_next;
`endif
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign bus_ncs   = r_ncs;
    assign bus_nwr   = r_nwr;
    assign bus_nrd   = r_nrd;
    assign bus_addr  = r_bus_addr;
    assign bus_dout  = r_bus_dout;

endmodule

// File: doc/vga_bus_master.md
Name: vga_bus_master

Overview:
Host-side initiator for the VGA core's asynchronous 8-bit register bus (ncs/nwr/nrd, 4-bit address, split data in/out). Converts a valid/ready request stream (from a UART bridge or soft CPU) into correctly timed bus write and read cycles, and returns read data on a response strobe. Sits on the FPGA/MCU side, driving the VGA core's bus pins.

Parameters:
SETUP_CYC, 1, cycles address/data are driven with strobes high before the strobe phase (>=1)
STROBE_CYC, 5, cycles ncs plus nwr/nrd are held low (>=1; 5 cycles = 20 ns at 250 MHz)
HOLD_CYC, 1, cycles address/data are held after the strobes deassert (>=1)
RECOVERY_CYC, 8, idle cycles with the bus parked before the next request is accepted (>=1)
POLL_LIMIT, 255, maximum status reads per busy-poll sequence (optional feature only)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block is in IDLE and accepts a request
req_write  in  1  1 = write, 0 = read
req_addr  in  4  register address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle pulse: read data valid
rsp_rdata  out  8  captured read data
bus_ncs  out  1  chip select, active low
bus_nwr  out  1  write strobe, active low
bus_nrd  out  1  read strobe, active low
bus_addr  out  4  bus address
bus_dout  out  8  data to VGA core
bus_din  in  8  data from VGA core
poll_timeout  out  1  sticky flag, busy-poll limit hit (tied 0 without macro)

Behaviour:
- One clock (clk); reset nrst is asynchronous and active-low.
- Reset values: bus_ncs=bus_nwr=bus_nrd=1, bus_addr=0, bus_dout=0, rsp_valid=0, rsp_rdata=0, poll_timeout=0, state IDLE.
- req_ready = (state==IDLE); it is 1 out of reset.
- All bus outputs are registered; no combinational path from req_* to bus_*.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. Each phase length is set by its parameter, counted by the phase timer.
- IDLE: on req_valid && req_ready, latch write/addr/wdata. The next edge enters SETUP and drives bus_addr and bus_dout (bus_dout is driven for writes only; it keeps its previous value for reads).
- STROBE: bus_ncs=0 and bus_nwr=0 (write) or bus_nrd=0 (read) for exactly STROBE_CYC cycles. Exactly one of nwr/nrd is low, never both.
- Read capture: bus_din is sampled on the clock edge that ends STROBE. rsp_rdata updates on that edge, and rsp_valid=1 for exactly the first HOLD cycle. Writes produce no rsp_valid.
- HOLD: strobes high; addr/dout unchanged.
- RECOVER: strobes high; addr/dout keep their values.
- Accept to next possible accept: SETUP+STROBE+HOLD+RECOVERY+1 cycles (16 with defaults).
- req_valid while not ready is ignored; req_* may change freely outside the accept cycle.
- Reset mid-cycle forces strobes high asynchronously. The in-flight transaction is dropped and no rsp_valid is issued.
- Phase counter width is $clog2(max phase parameter + 1). No wrap: the counter loads at phase entry and counts down to 0.

Optional Feature:
VGA_BUS_MASTER_BUSY_POLL_EN
- Defined: each accepted write to ADDR_DATA (3) is preceded by internal reads of ADDR_STATUS (0), using full bus cycles, repeated until status bit 0 (busy) reads 0. Then the write is issued. Poll reads never pulse rsp_valid.
- After POLL_LIMIT busy reads, the write is issued anyway and poll_timeout is set; it stays set until reset.
- Writes to other addresses and all reads are unaffected.
- Undefined: writes go straight to the bus and poll_timeout is constant 0.

Decomposition:
- Package vga_bus_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, RECOVER, POLL_RD, POLL_CHK);
  - address constants ADDR_STATUS=0, ADDR_CTRL=2, ADDR_DATA=3;
  - STATUS_BUSY_BIT=0.
- One sub-module, vga_bus_timer: loadable down-counter with a done flag, reused for every phase.

Test Plan:
- Write addr 3, data 0x42 (default params) -> bus_addr=3 and bus_dout=0x42 stable from SETUP through HOLD. bus_ncs/bus_nwr low exactly 5 cycles, bus_nrd stays 1. No rsp_valid.
- Read addr 0, bus_din=0xA5 during strobe -> bus_nrd low 5 cycles, rsp_rdata=0xA5, rsp_valid high one cycle in the first HOLD cycle.
- req_valid held high for writes (2,0x01) then (2,0x01) -> second strobe falls exactly 16 cycles after the first. Strobes are high for 11 cycles between them.
- Assert nrst during the 3rd strobe cycle of a read -> strobes go high without a clock edge. rsp_valid stays 0, req_ready=1 after release.
- Macro on, write (3,0x44), status returns 0x01, 0x01, then 0x00 -> three nrd cycles at addr 0, then one nwr cycle at addr 3 with 0x44. No rsp_valid, poll_timeout=0.
- Macro on, POLL_LIMIT=4, status stuck at 0x01 -> 4 poll reads, then the write is issued and poll_timeout=1 and stays 1.
